// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
// The optional grant counters are enabled by defining MEM_ARB_STATS_EN.
package mem_arb_pkg;

    localparam int MEM_AW = 12;
    localparam int MEM_DW = 8;

    localparam logic [15:0] GRANT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // Grant counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == GRANT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin pick between requester A and requester B.
// On a tie the port that was not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   a_req_i,
    input  logic   b_req_i,
    input  owner_e last_i,
    output logic   grant_valid_o,
    output owner_e grant_id_o
);

    always_comb begin
        grant_valid_o = a_req_i | b_req_i;
        grant_id_o    = OWN_A;
        if (a_req_i && b_req_i) begin
            grant_id_o = (last_i == OWN_A) ? OWN_B : OWN_A;
        end else if (b_req_i) begin
            grant_id_o = OWN_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin controller serialising A/B req/ack traffic onto a single-port memory.
// Define MEM_ARB_STATS_EN to enable the saturating per-port grant counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = MEM_AW,
    parameter int DW     = MEM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          mem_cen,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [15:0]   a_grants,
    output logic [15:0]   b_grants
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          cen_q, cen_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [1:0]    lat_q, lat_d;
    logic          aAck_q, aAck_d;
    logic          bAck_q, bAck_d;
    logic [DW-1:0] aRdata_q, aRdata_d;
    logic [DW-1:0] bRdata_q, bRdata_d;

    logic          grantValid;
    owner_e        grantId;

    mem_arb_rr u_rr (
        .a_req_i       (a_req),
        .b_req_i       (b_req),
        .last_i        (last_q),
        .grant_valid_o (grantValid),
        .grant_id_o    (grantId)
    );

    // Strobes and acks are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        lat_d    = lat_q;
        aRdata_d = aRdata_q;
        bRdata_d = bRdata_q;
        cen_d    = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        aAck_d   = 1'b0;
        bAck_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grantValid) begin
                    owner_d = grantId;
                    if (grantId == OWN_A) begin
                        we_d   = a_we;
                        addr_d = a_addr;
                        din_d  = a_wdata;
                    end else begin
                        we_d   = b_we;
                        addr_d = b_addr;
                        din_d  = b_wdata;
                    end
                    cen_d   = 1'b1;
                    wr_d    = we_d;
                    rd_d    = ~we_d;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    aAck_d  = (owner_q == OWN_A);
                    bAck_d  = (owner_q == OWN_B);
                    state_d = ST_RESP;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == 2'd0) begin
                    if (owner_q == OWN_A) begin
                        aRdata_d = mem_dout;
                        aAck_d   = 1'b1;
                    end else begin
                        bRdata_d = mem_dout;
                        bAck_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_RESP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset abandons any transaction in flight without acknowledging it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_A;
            last_q   <= OWN_B;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            cen_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            lat_q    <= 2'd0;
            aAck_q   <= 1'b0;
            bAck_q   <= 1'b0;
            aRdata_q <= '0;
            bRdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            cen_q    <= cen_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            lat_q    <= lat_d;
            aAck_q   <= aAck_d;
            bAck_q   <= bAck_d;
            aRdata_q <= aRdata_d;
            bRdata_q <= bRdata_d;
        end
    end

    assign mem_cen  = cen_q;
    assign mem_rd   = rd_q;
    assign mem_wr   = wr_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign a_ack    = aAck_q;
    assign b_ack    = bAck_q;
    assign a_rdata  = aRdata_q;
    assign b_rdata  = bRdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] aGrants_q, bGrants_q;

    // A grant is counted on the edge that moves the winner into ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aGrants_q <= 16'd0;
            bGrants_q <= 16'd0;
        end else if (state_q == ST_IDLE && grantValid) begin
            if (grantId == OWN_A) begin
                aGrants_q <= sat_inc(aGrants_q);
            end else begin
                bGrants_q <= sat_inc(bGrants_q);
            end
        end
    end

    assign a_grants = aGrants_q;
    assign b_grants = bGrants_q;
`else
    assign a_grants = 16'd0;
    assign b_grants = 16'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with behavioural memories at RD_LAT=1 and RD_LAT=3.
// Grant-counter expectations follow MEM_ARB_STATS_EN.
module tb_mem_arbiter;

    typedef struct {
        bit          port;
        bit          we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  expRd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        aReq = 1'b0, aWe = 1'b0, bReq = 1'b0, bWe = 1'b0;
    logic [11:0] aAddr = '0, bAddr = '0;
    logic [7:0]  aWdata = '0, bWdata = '0;
    logic        aAck, bAck, memCen, memRd, memWr;
    logic [7:0]  aRdata, bRdata, memDin;
    logic [7:0]  memDout = '0;
    logic [11:0] memAddr;
    logic [15:0] aGrants, bGrants;

    logic        sAReq = 1'b0, sAWe = 1'b0, sBReq = 1'b0, sBWe = 1'b0;
    logic [11:0] sAAddr = '0, sBAddr = '0;
    logic [7:0]  sAWdata = '0, sBWdata = '0;
    logic        sAAck, sBAck, sCen, sRd, sWr;
    logic [7:0]  sARdata, sBRdata, sDin;
    logic [11:0] sAddr;
    logic [15:0] sAGrants, sBGrants;
    logic [7:0]  p0 = '0, p1 = '0, p2 = '0;

    logic [7:0]  mem1 [4096];
    logic [7:0]  mem3 [4096];
    logic [7:0]  lastRd [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(12), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata), .a_ack(aAck), .a_rdata(aRdata),
        .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata), .b_ack(bAck), .b_rdata(bRdata),
        .mem_cen(memCen), .mem_rd(memRd), .mem_wr(memWr), .mem_addr(memAddr), .mem_din(memDin),
        .mem_dout(memDout), .a_grants(aGrants), .b_grants(bGrants)
    );

    mem_arbiter #(.AW(12), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_req(sAReq), .a_we(sAWe), .a_addr(sAAddr), .a_wdata(sAWdata), .a_ack(sAAck), .a_rdata(sARdata),
        .b_req(sBReq), .b_we(sBWe), .b_addr(sBAddr), .b_wdata(sBWdata), .b_ack(sBAck), .b_rdata(sBRdata),
        .mem_cen(sCen), .mem_rd(sRd), .mem_wr(sWr), .mem_addr(sAddr), .mem_din(sDin),
        .mem_dout(p2), .a_grants(sAGrants), .b_grants(sBGrants)
    );

    // Single-cycle read memory behind dut.
    always @(posedge clk) begin
        if (memCen && memWr) mem1[memAddr] <= memDin;
        if (memCen && memRd) memDout <= mem1[memAddr];
    end

    // Three-stage read pipeline behind dut3.
    always @(posedge clk) begin
        if (sCen && sWr) mem3[sAddr] <= sDin;
        if (sCen && sRd) p0 <= mem3[sAddr];
        p1 <= p0;
        p2 <= p1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit port, input bit req, input bit we,
                                 input logic [11:0] addr, input logic [7:0] wd);
        if (port == 1'b0) begin
            aReq = req; aWe = we; aAddr = addr; aWdata = wd;
        end else begin
            bReq = req; bWe = we; bAddr = addr; bWdata = wd;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " mem_cen"}, memCen, 0);
        checkOutput({tag, " mem_rd"}, memRd, 0);
        checkOutput({tag, " mem_wr"}, memWr, 0);
        checkOutput({tag, " mem_addr"}, memAddr, 0);
        checkOutput({tag, " mem_din"}, memDin, 0);
        checkOutput({tag, " a_ack"}, aAck, 0);
        checkOutput({tag, " b_ack"}, bAck, 0);
        checkOutput({tag, " a_rdata"}, aRdata, 0);
        checkOutput({tag, " b_rdata"}, bRdata, 0);
        checkOutput({tag, " a_grants"}, aGrants, 0);
        checkOutput({tag, " b_grants"}, bGrants, 0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;
    endtask

    // One complete transaction on dut from an idle arbiter, checking strobes, ack timing and rdata.
    task automatic txn(input bit port, input bit we, input logic [11:0] addr,
                       input logic [7:0] wd, input logic [7:0] expRd, input string name);
        int ackCyc;
        bit otherAck;
        int expLat;
        expLat   = we ? 2 : 3;
        ackCyc   = 0;
        otherAck = 1'b0;
        @(negedge clk);
        applyStimulus(port, 1'b1, we, addr, wd);
        for (int c = 1; c <= 12 && ackCyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput({name, " cen"}, memCen, 1);
                checkOutput({name, " wr"}, memWr, we);
                checkOutput({name, " rd"}, memRd, !we);
                checkOutput({name, " addr"}, memAddr, addr);
                if (we) checkOutput({name, " din"}, memDin, wd);
            end
            if ((port == 1'b0) ? aAck : bAck) ackCyc = c;
            if ((port == 1'b0) ? bAck : aAck) otherAck = 1'b1;
        end
        applyStimulus(port, 1'b0, we, addr, wd);
        checkOutput({name, " ack latency"}, ackCyc, expLat);
        checkOutput({name, " other ack"}, otherAck, 0);
        if (!we) lastRd[port] = expRd;
        checkOutput({name, " rdata"}, (port == 1'b0) ? aRdata : bRdata, lastRd[port]);
        @(negedge clk);
        checkOutput({name, " ack drop"}, (port == 1'b0) ? aAck : bAck, 0);
        checkOutput({name, " strobes idle"}, {memCen, memRd, memWr}, 0);
    endtask

    initial begin
        vec_t vecs [10];
        logic [11:0] grantLog [$];
        int aAckCyc, bAckCyc, firstGrantCyc, secondGrantCyc, rdPulses, ackCyc;
        logic [11:0] firstAddr, secondAddr;
        bit sawAck;
        logic [15:0] expA, expB;

        vecs[0] = '{port: 1'b0, we: 1'b1, addr: 12'h123, wdata: 8'h5A, expRd: 8'h00};
        vecs[1] = '{port: 1'b0, we: 1'b0, addr: 12'h123, wdata: 8'h00, expRd: 8'h5A};
        vecs[2] = '{port: 1'b1, we: 1'b1, addr: 12'h456, wdata: 8'hA5, expRd: 8'h00};
        vecs[3] = '{port: 1'b0, we: 1'b0, addr: 12'h456, wdata: 8'h00, expRd: 8'hA5};
        vecs[4] = '{port: 1'b1, we: 1'b0, addr: 12'h123, wdata: 8'h00, expRd: 8'h5A};
        vecs[5] = '{port: 1'b0, we: 1'b1, addr: 12'hFFF, wdata: 8'hFF, expRd: 8'h00};
        vecs[6] = '{port: 1'b1, we: 1'b0, addr: 12'hFFF, wdata: 8'h00, expRd: 8'hFF};
        vecs[7] = '{port: 1'b0, we: 1'b1, addr: 12'h000, wdata: 8'h01, expRd: 8'h00};
        vecs[8] = '{port: 1'b1, we: 1'b1, addr: 12'h000, wdata: 8'h80, expRd: 8'h00};
        vecs[9] = '{port: 1'b0, we: 1'b0, addr: 12'h000, wdata: 8'h00, expRd: 8'h80};

        mem3[12'hFFF] = 8'hC3;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRd,
                $sformatf("vec%0d", i));
        end

        // Tie from reset: A first, then B.
        pulseReset();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h001, 8'h11);
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h002, 8'h22);
        aAckCyc = 0; bAckCyc = 0; firstGrantCyc = 0; secondGrantCyc = 0;
        firstAddr = '0; secondAddr = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (memCen) begin
                if (firstGrantCyc == 0) begin
                    firstGrantCyc = c; firstAddr = memAddr;
                end else if (secondGrantCyc == 0) begin
                    secondGrantCyc = c; secondAddr = memAddr;
                end
            end
            if (aAck && aAckCyc == 0) begin aAckCyc = c; aReq = 1'b0; end
            if (bAck && bAckCyc == 0) begin bAckCyc = c; bReq = 1'b0; end
        end
        checkOutput("tie first grant cycle", firstGrantCyc, 1);
        checkOutput("tie first addr", firstAddr, 12'h001);
        checkOutput("tie a_ack cycle", aAckCyc, 2);
        checkOutput("tie second grant cycle", secondGrantCyc, 4);
        checkOutput("tie second addr", secondAddr, 12'h002);
        checkOutput("tie b_ack cycle", bAckCyc, 5);

        // Both held high: grants alternate A, B, A, B ...
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h010, 8'h33);
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h020, 8'h44);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (memCen) grantLog.push_back(memAddr);
        end
        aReq = 1'b0;
        bReq = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("alt grant count", grantLog.size() >= 8, 1);
        for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
            checkOutput($sformatf("alt grant %0d", i), grantLog[i], (i % 2 == 0) ? 12'h010 : 12'h020);
        end

        // B read of 0xFFF on the RD_LAT=3 instance.
        @(negedge clk);
        sBReq = 1'b1; sBWe = 1'b0; sBAddr = 12'hFFF;
        rdPulses = 0; ackCyc = 0; sawAck = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (sRd) rdPulses++;
            if (sAAck) sawAck = 1'b1;
            if (sBAck && ackCyc == 0) begin ackCyc = c; sBReq = 1'b0; end
        end
        checkOutput("lat3 rd pulses", rdPulses, 1);
        checkOutput("lat3 b_ack cycle", ackCyc, 5);
        checkOutput("lat3 b_rdata", sBRdata, 8'hC3);
        checkOutput("lat3 a_ack", sawAck, 0);

        // Reset in the WAIT state of an A read aborts it.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h123, 8'h00);
        @(negedge clk);
        checkOutput("abort issue rd", memRd, 1);
        @(negedge clk);
        rst = 1'b1;
        aReq = 1'b0;
        #1;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;
        checkResetState("abort");
        @(negedge clk);
        rst = 1'b0;
        sawAck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (aAck || bAck) sawAck = 1'b1;
        end
        checkOutput("abort no ack", sawAck, 0);
        txn(1'b0, 1'b0, 12'h123, 8'h00, 8'h5A, "reissue read");

        // Grant counters: 5 A grants, 3 B grants after reset.
        pulseReset();
        for (int i = 0; i < 5; i++) txn(1'b0, 1'b1, 12'h200 + 12'(i), 8'(i), 8'h00, $sformatf("statsA%0d", i));
        for (int i = 0; i < 3; i++) txn(1'b1, 1'b1, 12'h300 + 12'(i), 8'(i), 8'h00, $sformatf("statsB%0d", i));
`ifdef MEM_ARB_STATS_EN
        expA = 16'd5;
        expB = 16'd3;
`else
        expA = 16'd0;
        expB = 16'd0;
`endif
        checkOutput("a_grants", aGrants, expA);
        checkOutput("b_grants", bGrants, expB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin controller in front of the single-port 8-bit × 4K `memory`. Requester A and requester B each issue reads and writes through a req/ack handshake; the arbiter serialises them onto the memory's `cen/rd/wr/address/din` strobes and returns `dout`. It sits between the stimulus/agent side and `memory`, in the same top that binds `memory` and `checker`, so the checker observes the arbitrated bus unchanged.

## Interface
Parameters:
- `AW`, 12, address width
- `DW`, 8, data width
- `RD_LAT`, 1, cycles from read strobe to valid `mem_dout` (1..3)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `a_req` / `b_req`  in  1  request, held high until ack
- `a_we` / `b_we`  in  1  1 = write, 0 = read
- `a_addr` / `b_addr`  in  AW  address
- `a_wdata` / `b_wdata`  in  DW  write data
- `a_ack` / `b_ack`  out  1  one-cycle completion pulse
- `a_rdata` / `b_rdata`  out  DW  read data, valid with ack, held until next read ack to that port
- `mem_cen`, `mem_rd`, `mem_wr`  out  1  memory strobes, to `cen/rd/wr`
- `mem_addr`  out  AW  to `address`
- `mem_din`  out  DW  to `din`
- `mem_dout`  in  DW  from `dout`
- `a_grants` / `b_grants`  out  16  grant counters (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: no request pending → stay. One request pending → grant it. Both pending → grant the port not granted last. `last` resets to B, so A wins the first tie.
- On grant, latch the port's `we/addr/wdata` into `mem_*` registers and record the owner → ISSUE.
- ISSUE (1 cycle): `mem_cen=1`, and either `mem_wr=1` or `mem_rd=1`.
  - Write → RESP.
  - Read → WAIT, with latency counter loaded to `RD_LAT-1`.
- WAIT: decrement each cycle. At 0, capture `mem_dout` into the owner's `rdata` → RESP. If `RD_LAT=1`, WAIT lasts one cycle.
- RESP: pulse the owner's `ack` for 1 cycle, update `last`, return to IDLE.
- Strobes are low in every state except ISSUE. `mem_addr`/`mem_din` hold their last values outside ISSUE.
- Requester protocol:
  - `req` and its fields must stay stable until ack.
  - A `req` still high in the cycle after ack is a new request, arbitrated normally, so the other port wins a tie.
  - Dropping `req` before ack is a protocol violation; the transaction still completes.
- The non-owner port's `req` is ignored until IDLE.

## Timing
- Reset values: all strobes 0, `mem_addr=0`, `mem_din=0`, both `ack=0`, both `rdata=0`, counters 0, state IDLE, `last`=B.
- Reset asserted mid-transaction aborts immediately. No ack is issued; the requester must re-request.
- `req` is sampled at edge n in IDLE:
  - strobes are high in cycle n+1;
  - write ack is in cycle n+2;
  - read ack is in cycle n+2+RD_LAT.
- Minimum spacing between back-to-back grants: write 3 cycles, read 3+RD_LAT cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `a_grants`/`b_grants` count grants per port.
  - 16-bit, saturating at 0xFFFF.
  - Cleared by `rst`.
  - Incremented in the cycle the port enters ISSUE.
- Not defined: counter logic is omitted, and both ports remain but are tied to 0.

## Structure
- Package `mem_arb_pkg`:
  - state enum (`ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP`);
  - owner encoding (`OWN_A=0`, `OWN_B=1`);
  - default `AW`/`DW` constants.
- Sub-module `mem_arb_rr` (purely combinational): takes `a_req`, `b_req`, `last` and returns `grant_valid` and `grant_id`.
- The top-level test environment instantiates `mem_arbiter` between the two agents and `memory`; `checker` connects to the `mem_*` nets.

## Test plan
- Reset, then A write `addr=0x123`, `wdata=0x5A`:
  - `mem_wr=1`, `mem_addr=0x123`, `mem_din=0x5A` in cycle n+1;
  - `a_ack` in n+2;
  - `b_ack` never asserts.
- A read `0x123` after that write, `RD_LAT=1`: `a_ack` in n+3 with `a_rdata=0x5A`.
- A and B both request from reset:
  - A is granted first (write `0x001`←`0x11`), then B (write `0x002`←`0x22`);
  - with both held high continuously, grants alternate A, B, A, B.
- B read of `0xFFF` with `RD_LAT=3`: `mem_rd` pulses once, and `b_ack` arrives exactly 5 cycles after the req sample.
- `rst` pulsed during WAIT of an A read: all outputs return to reset values, no `a_ack`; a re-issued request completes normally.
- With `MEM_ARB_STATS_EN`, 5 A grants and 3 B grants give `a_grants=5`, `b_grants=3`; without the macro both read 0.
